board_io_bridge: RTL and testbench

//  Board-side I/O front end for FPGA prototyping of the chip design on Tang Nano class boards.
//  - Sequences the design reset from PLL lock and an external reset request.
//  - Synchronises and debounces NUM_BTN buttons.
//  - Synchronises NUM_IN PMOD inputs.
//  - Stretches NUM_LED event pulses onto active-low board LEDs.

---
 rtl/board_io_bridge.sv | 176 +++++++++++++++++
 tb/tb_board_io_bridge.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_bridge.sv
// Board-side I/O front end: reset sequencing from PLL lock, button debounce,
// PMOD input synchronisation and LED event stretching, all in the clk domain.
module board_io_bridge #(
  parameter int unsigned NUM_BTN         = 2,
  parameter int unsigned BTN_ACTIVE_LOW  = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned NUM_IN          = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned NUM_LED         = 6,
  parameter int unsigned STRETCH_CYCLES  = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               ext_rst_req,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_IN-1:0]  pmod_in_raw,
  input  logic [NUM_LED-1:0] led_evt,
  output logic               design_rst_n,
  output logic               design_ena,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_IN-1:0]  pmod_in_sync,
  output logic [NUM_LED-1:0] led_n
);

  localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LED_W  = $clog2(STRETCH_CYCLES + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LED_W-1:0]   LED_FULL  = LED_W'(STRETCH_CYCLES);
  localparam logic [NUM_BTN-1:0] BTN_POL   = (BTN_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    RUN
  } state_t;

  // Synchroniser chains; index SYNC_STAGES-1 is the settled stage.
  logic [SYNC_STAGES-1:0]              lock_sync;
  logic [SYNC_STAGES-1:0]              req_sync;
  logic [SYNC_STAGES-1:0][NUM_BTN-1:0] btn_sync;
  logic [SYNC_STAGES-1:0][NUM_IN-1:0]  pmod_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync <= '0;
      req_sync  <= '0;
      btn_sync  <= '0;
      pmod_sync <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
      req_sync  <= {req_sync[SYNC_STAGES-2:0], ext_rst_req};
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_raw};
      pmod_sync <= {pmod_sync[SYNC_STAGES-2:0], pmod_in_raw};
    end
  end

  logic               lock_s;
  logic               req_s;
  logic               lock_ok;
  logic [NUM_BTN-1:0] btn_s;

  assign lock_s       = lock_sync[SYNC_STAGES-1];
  assign req_s        = req_sync[SYNC_STAGES-1];
  assign btn_s        = btn_sync[SYNC_STAGES-1];
  assign pmod_in_sync = pmod_sync[SYNC_STAGES-1];
  assign lock_ok      = lock_s & ~req_s;

  // Reset sequencer
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_LOCK;
      hold_cnt_q   <= '0;
      design_rst_n <= 1'b0;
      design_ena   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      design_rst_n <= (state_q == RUN);
      design_ena   <= (state_q == RUN);
    end
  end

  // Losing lock (or a request) takes priority over finishing the hold count.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_ok) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        if (!lock_ok) begin
          state_d = WAIT_LOCK;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      RUN: begin
        if (!lock_ok) begin
          state_d = WAIT_LOCK;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Button debounce with press-edge detect
  logic [NUM_BTN-1:0]            btn_p;
  logic [NUM_BTN-1:0]            level_prev;
  logic [NUM_BTN-1:0][DEB_W-1:0] deb_cnt;

  assign btn_p = btn_s ^ BTN_POL;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level  <= '0;
      btn_press  <= '0;
      level_prev <= '0;
      deb_cnt    <= '0;
    end else begin
      level_prev <= btn_level;
      btn_press  <= btn_level & ~level_prev;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        if (btn_p[i] == btn_level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          btn_level[i] <= btn_p[i];
          deb_cnt[i]   <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // LED stretchers; led_n is registered from the next counter value.
  logic [NUM_LED-1:0][LED_W-1:0] led_cnt_q, led_cnt_d;

  always_comb begin
    led_cnt_d = led_cnt_q;
    for (int i = 0; i < int'(NUM_LED); i++) begin
      if (led_evt[i]) begin
        led_cnt_d[i] = LED_FULL;
      end else if (led_cnt_q[i] != '0) begin
        led_cnt_d[i] = led_cnt_q[i] - LED_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_cnt_q <= '0;
      led_n     <= '1;
    end else begin
      led_cnt_q <= led_cnt_d;
      for (int i = 0; i < int'(NUM_LED); i++) begin
        led_n[i] <= (led_cnt_d[i] == '0);
      end
    end
  end

endmodule

// File: tb/tb_board_io_bridge.sv
// Scoreboard bench for board_io_bridge: a per-edge reference model pushes the
// expected outputs, a negedge monitor pops and compares them.
module tb_board_io_bridge;

  localparam int NUM_BTN         = 2;
  localparam int BTN_ACTIVE_LOW  = 1;
  localparam int DEBOUNCE_CYCLES = 16;
  localparam int NUM_IN          = 8;
  localparam int SYNC_STAGES     = 2;
  localparam int RST_HOLD_CYCLES = 16;
  localparam int NUM_LED         = 6;
  localparam int STRETCH_CYCLES  = 1024;

  logic               clk = 1'b0;
  logic               rst;
  logic               pll_locked;
  logic               ext_rst_req;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_IN-1:0]  pmod_in_raw;
  logic [NUM_LED-1:0] led_evt;
  logic               design_rst_n;
  logic               design_ena;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_IN-1:0]  pmod_in_sync;
  logic [NUM_LED-1:0] led_n;

  always #5 clk = ~clk;

  board_io_bridge #(
    .NUM_BTN(NUM_BTN), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .NUM_IN(NUM_IN), .SYNC_STAGES(SYNC_STAGES), .RST_HOLD_CYCLES(RST_HOLD_CYCLES),
    .NUM_LED(NUM_LED), .STRETCH_CYCLES(STRETCH_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .ext_rst_req(ext_rst_req),
    .btn_raw(btn_raw), .pmod_in_raw(pmod_in_raw), .led_evt(led_evt),
    .design_rst_n(design_rst_n), .design_ena(design_ena), .btn_level(btn_level),
    .btn_press(btn_press), .pmod_in_sync(pmod_in_sync), .led_n(led_n)
  );

  typedef struct packed {
    logic               rst_n;
    logic               ena;
    logic [NUM_BTN-1:0] lvl;
    logic [NUM_BTN-1:0] press;
    logic [NUM_IN-1:0]  pmod;
    logic [NUM_LED-1:0] led_n;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state, expressed as histories and streak lengths.
  logic               lock_h[$];
  logic               req_h[$];
  logic [NUM_BTN-1:0] btn_h[$];
  logic [NUM_IN-1:0]  pmod_h[$];
  int                 good_streak;
  logic               run_m;
  logic [NUM_BTN-1:0] lvl_m, lvl_old_m;
  int                 differ_run[NUM_BTN];
  longint             edge_n;
  longint             last_evt[NUM_LED];
  bit                 evt_seen[NUM_LED];

  function automatic void model_edge();
    exp_t               e;
    logic               lock_s, req_s;
    logic [NUM_BTN-1:0] p;
    if (rst) begin
      lock_h.delete(); req_h.delete(); btn_h.delete(); pmod_h.delete();
      for (int k = 0; k < SYNC_STAGES; k++) begin
        lock_h.push_back(1'b0); req_h.push_back(1'b0);
        btn_h.push_back('0);    pmod_h.push_back('0);
      end
      good_streak = 0;
      run_m       = 1'b0;
      lvl_m       = '0;
      lvl_old_m   = '0;
      for (int i = 0; i < NUM_BTN; i++) differ_run[i] = 0;
      for (int i = 0; i < NUM_LED; i++) evt_seen[i] = 1'b0;
      edge_n  = 0;
      e.rst_n = 1'b0;
      e.ena   = 1'b0;
      e.lvl   = '0;
      e.press = '0;
      e.pmod  = '0;
      e.led_n = '1;
    end else begin
      lock_s = lock_h[SYNC_STAGES-1];
      req_s  = req_h[SYNC_STAGES-1];
      p      = btn_h[SYNC_STAGES-1] ^ ((BTN_ACTIVE_LOW != 0) ? {NUM_BTN{1'b1}} : {NUM_BTN{1'b0}});
      // Design runs once lock has been good for the hold time plus the entry edge.
      e.rst_n = run_m;
      e.ena   = run_m;
      if (lock_s && !req_s) begin
        if (good_streak <= RST_HOLD_CYCLES) good_streak++;
      end else begin
        good_streak = 0;
      end
      run_m   = (good_streak >= RST_HOLD_CYCLES + 1);
      e.press = lvl_m & ~lvl_old_m;
      lvl_old_m = lvl_m;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (p[i] != lvl_m[i]) begin
          differ_run[i]++;
          if (differ_run[i] == DEBOUNCE_CYCLES) begin
            lvl_m[i]      = p[i];
            differ_run[i] = 0;
          end
        end else begin
          differ_run[i] = 0;
        end
      end
      e.lvl = lvl_m;
      lock_h.push_front(pll_locked);  void'(lock_h.pop_back());
      req_h.push_front(ext_rst_req);  void'(req_h.pop_back());
      btn_h.push_front(btn_raw);      void'(btn_h.pop_back());
      pmod_h.push_front(pmod_in_raw); void'(pmod_h.pop_back());
      e.pmod = pmod_h[SYNC_STAGES-1];
      for (int i = 0; i < NUM_LED; i++) begin
        if (led_evt[i]) begin
          evt_seen[i] = 1'b1;
          last_evt[i] = edge_n;
        end
        e.led_n[i] = !(evt_seen[i] && (edge_n - last_evt[i] < longint'(STRETCH_CYCLES)));
      end
      edge_n++;
    end
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one expectation per clock.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("design_rst_n", 32'(design_rst_n), 32'(e.rst_n));
        check("design_ena",   32'(design_ena),   32'(e.ena));
        check("btn_level",    32'(btn_level),    32'(e.lvl));
        check("btn_press",    32'(btn_press),    32'(e.press));
        check("pmod_in_sync", 32'(pmod_in_sync), 32'(e.pmod));
        check("led_n",        32'(led_n),        32'(e.led_n));
      end
    end
  end

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      pmod_in_raw = NUM_IN'($urandom);
      cycle();
      led_evt = '0;
    end
  endtask

  initial begin : stim
    int lock_hold;
    int req_hold;
    int btn_hold[NUM_BTN];
    rst = 1'b1; pll_locked = 1'b1; ext_rst_req = 1'b0;
    btn_raw = '1; pmod_in_raw = '0; led_evt = '0;
    tick(3);
    rst = 1'b0;
    tick(30);
    // Short glitch, then a real press and release on button 0
    btn_raw[0] = 1'b0; tick(10);
    btn_raw[0] = 1'b1; tick(30);
    btn_raw[0] = 1'b0; tick(40);
    btn_raw[0] = 1'b1; tick(40);
    // One-cycle lock drop while running, then full re-hold
    pll_locked = 1'b0; tick(1);
    pll_locked = 1'b1; tick(40);
    // Reset request pulse while running
    ext_rst_req = 1'b1; tick(3);
    ext_rst_req = 1'b0; tick(40);
    // LED retrigger while lit, then let it expire
    led_evt[2] = 1'b1; tick(1); tick(499);
    led_evt[2] = 1'b1; tick(1); tick(1100);
    // Randomised traffic with occasional resets
    lock_hold = 0; req_hold = 0;
    for (int i = 0; i < NUM_BTN; i++) btn_hold[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      if (lock_hold == 0) begin
        pll_locked = ($urandom_range(0, 9) != 0);
        lock_hold  = pll_locked ? int'($urandom_range(20, 200)) : int'($urandom_range(1, 5));
      end else begin
        lock_hold--;
      end
      if (req_hold > 0) begin
        ext_rst_req = 1'b1;
        req_hold--;
      end else begin
        ext_rst_req = 1'b0;
        if ($urandom_range(0, 299) == 0) req_hold = int'($urandom_range(1, 3));
      end
      for (int i = 0; i < NUM_BTN; i++) begin
        if (btn_hold[i] == 0) begin
          btn_raw[i]  = 1'($urandom_range(0, 1));
          btn_hold[i] = int'($urandom_range(1, 40));
        end else begin
          btn_hold[i]--;
        end
      end
      for (int i = 0; i < NUM_LED; i++) led_evt[i] = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(5);
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
